// File: rtl/axis_dest_router.sv
// AXI4-Stream 1-to-2 destination router: routes whole packets by one-hot tdest
// into per-port FIFOs, discards and counts packets with an unknown tdest.

module axis_dest_router_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Pointers are exactly AW bits wide, so the +1 wraps modulo DEPTH on its own.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

module axis_dest_router #(
   parameter int                 DATA_W     = 8,
   parameter int                 DEST_W     = 5,
   parameter int                 FIFO_DEPTH = 4,
   parameter logic [DEST_W-1:0]  DEST0      = 5'b00001,
   parameter logic [DEST_W-1:0]  DEST1      = 5'b00010
) (
   input  logic              i_sclk,
   input  logic              i_srst_n,
   input  logic              i_s_tvalid,
   output logic              o_s_tready,
   input  logic [DEST_W-1:0] i_s_tdest,
   input  logic [DATA_W-1:0] i_s_tdata,
   input  logic              i_s_tlast,
   output logic              o_m0_tvalid,
   input  logic              i_m0_tready,
   output logic [DATA_W-1:0] o_m0_tdata,
   output logic              o_m0_tlast,
   output logic              o_m1_tvalid,
   input  logic              i_m1_tready,
   output logic [DATA_W-1:0] o_m1_tdata,
   output logic              o_m1_tlast,
   output logic [7:0]        o_drop_cnt,
   output logic              o_busy
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ROUTE0 = 2'd1;
   localparam logic [1:0] ST_ROUTE1 = 2'd2;
   localparam logic [1:0] ST_DROP   = 2'd3;

   localparam logic [1:0] T_P0   = 2'd0;
   localparam logic [1:0] T_P1   = 2'd1;
   localparam logic [1:0] T_DROP = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;
   logic [1:0] target;
   logic       accept;
   logic       push0, push1, pop0, pop1;
   logic       full0, full1, empty0, empty1;
   logic [DATA_W:0] head0, head1;

   // tdest is only decoded on the first beat; later beats follow the locked route.
   always_comb begin
      target = T_DROP;
      case (state_q)
         ST_IDLE: begin
            if (i_s_tdest == DEST0)      target = T_P0;
            else if (i_s_tdest == DEST1) target = T_P1;
            else                         target = T_DROP;
         end
         ST_ROUTE0: target = T_P0;
         ST_ROUTE1: target = T_P1;
         default:   target = T_DROP;
      endcase
   end

   always_comb begin
      o_s_tready = 1'b0;
      case (target)
         T_P0:    o_s_tready = !full0;
         T_P1:    o_s_tready = !full1;
         default: o_s_tready = 1'b1;
      endcase
   end

   assign accept = i_s_tvalid && o_s_tready;
   assign push0  = accept && (target == T_P0);
   assign push1  = accept && (target == T_P1);
   assign pop0   = !empty0 && i_m0_tready;
   assign pop1   = !empty1 && i_m1_tready;

   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      if (accept) begin
         if (i_s_tlast) begin
            state_d = ST_IDLE;
            if (target == T_DROP && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
         end else begin
            case (target)
               T_P0:    state_d = ST_ROUTE0;
               T_P1:    state_d = ST_ROUTE1;
               default: state_d = ST_DROP;
            endcase
         end
      end
   end

   always_ff @(posedge i_sclk or negedge i_srst_n) begin
      if (!i_srst_n) begin
         state_q    <= ST_IDLE;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   axis_dest_router_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk       (i_sclk),
      .rst_n     (i_srst_n),
      .push      (push0),
      .push_data ({i_s_tlast, i_s_tdata}),
      .pop       (pop0),
      .full      (full0),
      .empty     (empty0),
      .head      (head0)
   );

   axis_dest_router_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk       (i_sclk),
      .rst_n     (i_srst_n),
      .push      (push1),
      .push_data ({i_s_tlast, i_s_tdata}),
      .pop       (pop1),
      .full      (full1),
      .empty     (empty1),
      .head      (head1)
   );

   assign o_m0_tvalid = !empty0;
   assign o_m0_tlast  = head0[DATA_W];
   assign o_m0_tdata  = head0[DATA_W-1:0];
   assign o_m1_tvalid = !empty1;
   assign o_m1_tlast  = head1[DATA_W];
   assign o_m1_tdata  = head1[DATA_W-1:0];
   assign o_drop_cnt  = drop_cnt_q;
   assign o_busy      = (state_q != ST_IDLE);
endmodule

// File: doc/axis_dest_router.md
Name: axis_dest_router

Overview:
- AXI4-Stream 1-to-2 destination router. Sits directly downstream of the stream master and consumes its tvalid/tready/tdest/tdata/tlast stream.
- Decodes one-hot tdest (5'b00001 → port 0, 5'b00010 → port 1) once per packet and locks that route until tlast.
- Buffers beats in a per-output FIFO and presents them on two AXI4-Stream master ports.
- Accepts and discards packets with an unknown tdest, counting each one.

Parameters:
- DATA_W, 8, tdata width.
- DEST_W, 5, tdest width.
- FIFO_DEPTH, 4, entries per output FIFO; power of two, ≥2.
- DEST0, 5'b00001, tdest value routed to port 0.
- DEST1, 5'b00010, tdest value routed to port 1.

Ports:
- i_sclk  in  1  clock.
- i_srst_n  in  1  reset; asynchronous assert, active-low.
- i_s_tvalid  in  1  upstream beat valid.
- o_s_tready  out  1  router can accept the beat.
- i_s_tdest  in  DEST_W  beat destination.
- i_s_tdata  in  DATA_W  beat payload.
- i_s_tlast  in  1  last beat of packet.
- o_m0_tvalid / i_m0_tready / o_m0_tdata[DATA_W] / o_m0_tlast  out/in/out/out  port-0 stream.
- o_m1_tvalid / i_m1_tready / o_m1_tdata[DATA_W] / o_m1_tlast  out/in/out/out  port-1 stream.
- o_drop_cnt  out  8  packets discarded for unknown tdest; saturating.
- o_busy  out  1  high while a packet is mid-route (state ≠ IDLE).

Behaviour:
- Reset (i_srst_n=0, async):
  - state=IDLE; both FIFOs empty (pointers and counts 0).
  - o_m0_tvalid=o_m1_tvalid=0; o_m*_tdata=0; o_m*_tlast=0.
  - o_drop_cnt=0; o_busy=0.
  - Reset mid-packet discards all buffered and partial data. No output beat is produced after reset until new input is accepted.
- Handshakes:
  - A transfer occurs on a rising edge with tvalid&&tready.
  - The router never deasserts o_m*_tvalid, or changes o_m*_tdata/tlast, while tvalid is high without a matching tready.
- Route selection (combinational target):
  - IDLE: target decoded from the current i_s_tdest. DEST0 → P0, DEST1 → P1, any other value (including 0 and multi-hot) → DROP.
  - ROUTE0 / ROUTE1 / DROP: target is the locked route. i_s_tdest is ignored on non-first beats.
- o_s_tready, combinational and independent of i_s_tvalid:
  - 1 when target=P0 and FIFO0 is not full.
  - 1 when target=P1 and FIFO1 is not full.
  - 1 when target=DROP.
  - 0 otherwise.
  - A full FIFO blocks the input even if the same edge pops. There is no pop-to-push bypass.
- FSM, state changes on accepted beats only:
  - IDLE, first beat with tlast=1: stay IDLE (single-beat packet). If DROP, increment o_drop_cnt.
  - IDLE, first beat with tlast=0: go to ROUTE0, ROUTE1 or DROP per the decode.
  - ROUTEx/DROP, beat with tlast=0: hold state.
  - ROUTEx/DROP, beat with tlast=1: return to IDLE. Leaving DROP increments o_drop_cnt.
  - o_drop_cnt increments once per dropped packet, on its tlast beat, and saturates at 8'hFF.
- FIFOs:
  - Each entry stores {tlast, tdata}. Push on an accepted beat to the locked/target port.
  - Pop on o_mx_tvalid && i_mx_tready.
  - o_mx_tvalid = FIFO not empty.
  - o_mx_tdata/tlast = the head entry, registered or read from the storage array with no combinational path from input.
  - Latency: a beat accepted at edge N into an empty FIFO is visible on output at edge N (valid from cycle N+1).
  - Simultaneous push and pop with the FIFO neither empty nor full: count is unchanged and order is preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1, so full and empty are distinguishable.
- Independence: ports 0 and 1 drain independently. Back-pressure on one port stalls only packets targeting that port, i.e. it stalls the input while that port is the target.

Test Plan:
- Reset, then a single beat {tdest=00001, tdata=8'hA5, tlast=1} → o_m0_tvalid=1 from the next cycle with tdata=A5, tlast=1; o_m1_tvalid stays 0; state IDLE.
- 3-beat packet to 00010 (data 11,22,33; tdest changed to 00001 on beats 2–3), i_m1_tready=1 → port 1 emits 11,22,33 with tlast only on 33; port 0 emits nothing.
- Packet to 00001 of 6 beats with FIFO_DEPTH=4, i_m0_tready=0 → o_s_tready falls after 4 accepts. Raising i_m0_tready drains in order, the remaining 2 beats are accepted, and no beat is lost or duplicated.
- Unknown tdest 00100: 2-beat packet then 1-beat packet → o_s_tready=1 throughout; no output valid; o_drop_cnt=2. After 300 dropped packets, o_drop_cnt=8'hFF.
- Interleaved packets P0(A,B) then P1(C) with i_m0_tready=0 → input stalls only once FIFO0 is full; P1 proceeds after the P0 packet completes; port 1 emits C while port 0 still holds A,B.
- Assert i_srst_n=0 mid-packet with both FIFOs non-empty → all tvalid drop immediately (async); after release, o_busy=0, o_drop_cnt=0, and the next packet routes by its own tdest.
